seq_calc_alu: RTL and testbench



---
 rtl/seq_calc_alu.sv | 147 ++++++++++++++
 tb/tb_seq_calc_alu.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_calc_alu.sv
// rtl/seq_calc_alu.sv - sequenced add/sub/logic/shift-add multiply/restoring divide ALU
module seq_calc_alu #(
  parameter int W = 4
) (
  input  logic           MAX10_CLK1_50,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2:0]     op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] result,
  output logic           carry,
  output logic           overflow,
  output logic           div_by_zero
);

  localparam int CW = $clog2(W + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;
  localparam logic [2:0] OP_DIV = 3'b110;
  localparam logic [2:0] OP_NOT = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state;
  logic [2:0]     op_q;
  logic [W-1:0]   a_q;
  logic [W-1:0]   b_q;
  logic [2*W-1:0] acc;
  logic [CW-1:0]  cnt;

  logic           iterative;
  logic [W:0]     sum;
  logic [W:0]     diff;
  logic [W:0]     mul_sum;
  logic [W:0]     rem_sh;
  logic [W:0]     trial;
  logic [2*W-1:0] mul_next;
  logic [2*W-1:0] div_next;
  logic [2*W-1:0] single_res;
  logic           single_carry;
  logic           single_ovf;

  // acc holds {upper product, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    sum      = {1'b0, a_q} + {1'b0, b_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, a_q} : {(W+1){1'b0}});
    mul_next = {mul_sum, acc[W-1:1]};
    rem_sh   = acc[2*W-1:W-1];
    trial    = rem_sh - {1'b0, b_q};
    div_next = trial[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                        : {trial[W-1:0], acc[W-2:0], 1'b1};
    iterative = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

    single_res   = '0;
    single_carry = 1'b0;
    single_ovf   = 1'b0;
    case (op_q)
      OP_ADD: begin
        single_res   = {{(W-1){1'b0}}, sum};
        single_carry = sum[W];
        single_ovf   = (a_q[W-1] == b_q[W-1]) && (sum[W-1] != a_q[W-1]);
      end
      OP_SUB: begin
        single_res   = {{W{1'b0}}, diff[W-1:0]};
        single_carry = diff[W];
        single_ovf   = (a_q[W-1] != b_q[W-1]) && (diff[W-1] != a_q[W-1]);
      end
      OP_AND:  single_res = {{W{1'b0}}, a_q & b_q};
      OP_OR:   single_res = {{W{1'b0}}, a_q | b_q};
      OP_XOR:  single_res = {{W{1'b0}}, a_q ^ b_q};
      OP_NOT:  single_res = {{W{1'b0}}, ~a_q};
      OP_DIV:  single_res = {a_q, {W{1'b1}}};
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      result      <= '0;
      carry       <= 1'b0;
      overflow    <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            a_q   <= a;
            b_q   <= b;
            cnt   <= CW'(W);
            acc   <= (op == OP_MUL) ? {{W{1'b0}}, b} : {{W{1'b0}}, a};
            busy  <= 1'b1;
            state <= CALC;
          end
        end
        CALC: begin
          if (!iterative) begin
            result      <= single_res;
            carry       <= single_carry;
            overflow    <= single_ovf;
            div_by_zero <= (op_q == OP_DIV);
            busy        <= 1'b0;
            done        <= 1'b1;
            state       <= DONE;
          end else begin
            acc <= (op_q == OP_MUL) ? mul_next : div_next;
            cnt <= cnt - CW'(1);
            // last iteration publishes the freshly stepped value directly
            if (cnt == CW'(1)) begin
              result      <= (op_q == OP_MUL) ? mul_next : div_next;
              carry       <= (op_q == OP_MUL) ? (|mul_next[2*W-1:W]) : 1'b0;
              overflow    <= 1'b0;
              div_by_zero <= 1'b0;
              busy        <= 1'b0;
              done        <= 1'b1;
              state       <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_calc_alu.sv
// tb/tb_seq_calc_alu.sv - self-checking bench for seq_calc_alu (W=4 and W=8 instances)
module tb_seq_calc_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] op;
  logic [3:0] a, b;
  logic       busy, done, carry, overflow, div_by_zero;
  logic [7:0] result;

  logic       start8;
  logic [2:0] op8;
  logic [7:0] a8, b8;
  logic       busy8, done8, carry8, overflow8, dbz8;
  logic [15:0] result8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_calc_alu #(.W(4)) dut (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .carry(carry),
    .overflow(overflow), .div_by_zero(div_by_zero)
  );

  seq_calc_alu #(.W(8)) dut8 (
    .MAX10_CLK1_50(clk), .rst_n(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .carry(carry8),
    .overflow(overflow8), .div_by_zero(dbz8)
  );

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    bit         c;
    bit         v;
    bit         z;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference from arithmetic rules: plain integer add/sub/mul/div on 4-bit values
  function automatic void model(input int o, input int x, input int y,
                                output int r, output bit c, output bit v, output bit z);
    int sx, sy;
    sx = (x >= 8) ? x - 16 : x;
    sy = (y >= 8) ? y - 16 : y;
    r = 0; c = 0; v = 0; z = 0;
    case (o)
      0: begin r = x + y; c = (r > 15); v = (sx + sy > 7) || (sx + sy < -8); end
      1: begin r = (x - y) & 15; c = (x < y); v = (sx - sy > 7) || (sx - sy < -8); end
      2: r = x & y;
      3: r = x | y;
      4: r = x ^ y;
      5: begin r = x * y; c = (r > 15); end
      6: if (y == 0) begin r = (x << 4) | 15; z = 1; end
         else r = ((x % y) << 4) | (x / y);
      default: r = (~x) & 15;
    endcase
  endfunction

  int bothhigh = 0;
  always @(negedge clk) if (busy && done) bothhigh++;

  task automatic run_op(input logic [2:0] o, input logic [3:0] x, input logic [3:0] y,
                        output int lat, output logic [7:0] r, output logic c,
                        output logic v, output logic z);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1'b1);
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
    r = result; c = carry; v = overflow; z = div_by_zero;
    @(posedge clk); #1;
    check("done_single_pulse", done, 1'b0);
  endtask

  int lat, ndone, t0, t1, t2, mr;
  logic [7:0] r;
  logic c, v, z;
  bit mc, mv, mz;

  initial begin
    rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
    start8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, done, result, carry, overflow, div_by_zero}, '0);
    @(negedge clk); rst_n = 1'b1;

    vecs[0] = '{3'd0, 4'd9,  4'd8,  8'h11, 1, 1, 0, 1};
    vecs[1] = '{3'd1, 4'd3,  4'd5,  8'h0E, 1, 0, 0, 1};
    vecs[2] = '{3'd5, 4'd15, 4'd15, 8'hE1, 1, 0, 0, 4};
    vecs[3] = '{3'd5, 4'd3,  4'd5,  8'h0F, 0, 0, 0, 4};
    vecs[4] = '{3'd6, 4'd13, 4'd4,  8'h13, 0, 0, 0, 4};
    vecs[5] = '{3'd6, 4'd7,  4'd0,  8'h7F, 0, 0, 1, 1};
    vecs[6] = '{3'd2, 4'hC,  4'hA,  8'h08, 0, 0, 0, 1};
    vecs[7] = '{3'd3, 4'hC,  4'hA,  8'h0E, 0, 0, 0, 1};
    vecs[8] = '{3'd4, 4'hC,  4'hA,  8'h06, 0, 0, 0, 1};
    vecs[9] = '{3'd7, 4'hC,  4'hA,  8'h03, 0, 0, 0, 1};

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, r, c, v, z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_carry", i), c, vecs[i].c);
      check($sformatf("vec%0d_overflow", i), v, vecs[i].v);
      check($sformatf("vec%0d_dbz", i), z, vecs[i].z);
    end

    for (int i = 0; i < 60; i++) begin
      logic [2:0] ro;
      logic [3:0] ra, rb;
      ro = 3'($urandom_range(0, 7));
      ra = 4'($urandom_range(0, 15));
      rb = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      model(int'(ro), int'(ra), int'(rb), mr, mc, mv, mz);
      run_op(ro, ra, rb, lat, r, c, v, z);
      check($sformatf("rnd%0d_op%0d_%0d_%0d_latency", i, ro, ra, rb), lat,
            ((ro == 3'd5) || (ro == 3'd6 && rb != 0)) ? 4 : 1);
      check($sformatf("rnd%0d_op%0d_%0d_%0d_outputs", i, ro, ra, rb),
            {r, c, v, z}, {mr[7:0], mc, mv, mz});
    end

    // start pulses and operand changes during a mul are ignored
    @(negedge clk); op = 3'd5; a = 4'd3; b = 4'd5; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0; lat = -1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i <= 2) begin a = 4'd15; b = 4'd15; op = 3'd0; end
      start = (i == 1 || i == 5);
      @(posedge clk); #1;
      if (done) begin ndone++; if (lat < 0) lat = i; r = result; end
    end
    check("mul_ignore_done_count", ndone, 1);
    check("mul_ignore_latency", lat, 4);
    check("mul_ignore_result", r, 8'h0F);

    // start held high: one completion every W+2 (mul) or 3 (single) cycles
    for (int pass = 0; pass < 2; pass++) begin
      @(negedge clk); op = (pass == 0) ? 3'd5 : 3'd2; a = 4'd2; b = 4'd3; start = 1'b1;
      t0 = -1; t1 = -1; t2 = -1;
      for (int i = 1; i <= 30; i++) begin
        @(posedge clk); #1;
        if (done) begin
          if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i; else if (t2 < 0) t2 = i;
        end
      end
      @(negedge clk); start = 1'b0;
      repeat (10) @(posedge clk);
      check($sformatf("held_start_period1_pass%0d", pass), t1 - t0, (pass == 0) ? 6 : 3);
      check($sformatf("held_start_period2_pass%0d", pass), t2 - t1, (pass == 0) ? 6 : 3);
    end

    // asynchronous reset aborts a divide mid-flight
    run_op(3'd0, 4'd9, 4'd8, lat, r, c, v, z);
    check("pre_reset_result", r, 8'h11);
    @(negedge clk); op = 3'd6; a = 4'd13; b = 4'd4; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {busy, done, result, carry, overflow, div_by_zero}, '0);
    ndone = 0;
    repeat (2) begin @(posedge clk); #1; if (done) ndone++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin @(posedge clk); #1; if (done) ndone++; end
    check("no_done_after_abort", ndone, 0);
    run_op(3'd6, 4'd13, 4'd4, lat, r, c, v, z);
    check("post_reset_div_latency", lat, 4);
    check("post_reset_div_result", {r, z}, {8'h13, 1'b0});

    // W=8 multiply
    @(negedge clk); op8 = 3'd5; a8 = 8'd255; b8 = 8'd255; start8 = 1'b1;
    @(posedge clk); #1; start8 = 1'b0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    check("w8_mul_latency", lat, 8);
    check("w8_mul_result", result8, 16'hFE01);
    check("w8_mul_carry", carry8, 1'b1);

    check("busy_done_never_both", bothhigh, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
